// File: rtl/rng_mask_buffer.sv
// Consumer-side front end for the Trivium64 RNG: sequences reseeding, discards the first
// words after each reseed and buffers random words for the masking gadgets.
module rng_mask_buffer #(
  parameter int unsigned INSTANCES = 5,
  parameter int unsigned WIDTH     = INSTANCES * 64,
  parameter int unsigned SEED_W    = INSTANCES * 80,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DISCARD   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEED_W-1:0]          seed_in,
  input  logic                       reseed_req,
  output logic                       rng_enable,
  output logic                       rng_reseed,
  output logic [SEED_W-1:0]          rng_seed,
  input  logic                       rng_ready,
  input  logic [WIDTH-1:0]           rng_random,
  output logic                       rnd_valid,
  input  logic                       rnd_ready,
  output logic [WIDTH-1:0]           rnd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
  output logic [31:0]                words_served
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StReseed, StWaitRdy, StDrop, StRun} state_e;

  state_e             state_q;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]    level_q;
  logic [3:0]         disc_q;
  logic [31:0]        served_q;
  logic [SEED_W-1:0]  seed_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic in_run, full, push, pop;

  assign in_run = (state_q == StRun);
  assign full   = (level_q == LvlW'(DEPTH));

  // A reseed request kills any handshake in the same cycle so no word can leak past a flush.
  assign rnd_valid = in_run && (level_q != '0) && !reseed_req;
  assign pop       = rnd_valid && rnd_ready;

  always_comb begin
    rng_enable = 1'b0;
    unique case (state_q)
      StReseed, StWaitRdy, StDrop: rng_enable = 1'b1;
      StRun:                       rng_enable = !full || pop;
      default:                     rng_enable = 1'b0;
    endcase
  end

  assign push = in_run && rng_enable && rng_ready && !reseed_req;

  assign rng_reseed   = (state_q == StReseed);
  assign rng_seed     = seed_q;
  assign rnd_data     = rnd_valid ? mem_q[rd_ptr_q] : '0;
  assign level        = level_q;
  assign busy         = !in_run;
  assign words_served = served_q;

  // Storage needs no reset: it is only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rng_random;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      disc_q   <= '0;
      served_q <= '0;
      seed_q   <= '0;
    end else if (reseed_req) begin
      state_q  <= StReseed;
      seed_q   <= seed_in;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      disc_q   <= 4'(DISCARD);
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StIdle;
        end
        StReseed: begin
          state_q <= StWaitRdy;
        end
        StWaitRdy: begin
          if (rng_ready) begin
            state_q <= (DISCARD > 0) ? StDrop : StRun;
          end
        end
        StDrop: begin
          if (rng_ready) begin
            disc_q <= disc_q - 4'd1;
            if (disc_q == 4'd1) begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
          end
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
            served_q <= served_q + 32'd1;
          end
          unique case ({push, pop})
            2'b10:   level_q <= level_q + LvlW'(1);
            2'b01:   level_q <= level_q - LvlW'(1);
            default: level_q <= level_q;
          endcase
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_mask_buffer.sv
// Bench for rng_mask_buffer: a counting RNG model feeds the DUT and a word queue
// scoreboards every delivered word, the occupancy and the transfer count.
module tb_rng_mask_buffer;

  localparam int WIDTH   = 320;
  localparam int SEED_W  = 400;
  localparam int DEPTH   = 4;
  localparam int DISCARD = 2;

  typedef logic [399:0] val_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [SEED_W-1:0] seed_in;
  logic              reseed_req;
  logic              rng_enable, rng_reseed;
  logic [SEED_W-1:0] rng_seed;
  logic              rng_ready;
  logic [WIDTH-1:0]  rng_random;
  logic              rnd_valid, rnd_ready;
  logic [WIDTH-1:0]  rnd_data;
  logic [2:0]        level;
  logic              busy;
  logic [31:0]       words_served;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] gen = '0;
  logic [31:0] k = '0;
  logic        primed = 1'b0;
  logic [WIDTH-1:0] q[$];
  logic [31:0] served_exp = '0;
  logic [SEED_W-1:0] seed_a, seed_b;

  rng_mask_buffer #(
    .INSTANCES (5),
    .DEPTH     (DEPTH),
    .DISCARD   (DISCARD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seed_in      (seed_in),
    .reseed_req   (reseed_req),
    .rng_enable   (rng_enable),
    .rng_reseed   (rng_reseed),
    .rng_seed     (rng_seed),
    .rng_ready    (rng_ready),
    .rng_random   (rng_random),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .rnd_data     (rnd_data),
    .level        (level),
    .busy         (busy),
    .words_served (words_served)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] word_of(input logic [31:0] g, input logic [31:0] kk);
    return {5{g ^ 32'hC3A5_0000, kk}};
  endfunction

  task automatic check_eq(input string tag, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RNG model: the first ready edge after a reseed only announces readiness; every later
  // enabled, ready edge consumes the presented word and moves to the next.
  assign rng_random = word_of(gen, k);

  always @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      primed <= 1'b0;
    end else if (rng_reseed) begin
      k      <= '0;
      primed <= 1'b0;
      gen    <= gen + 32'd1;
    end else if (rng_enable && rng_ready) begin
      if (primed) k <= k + 32'd1;
      else        primed <= 1'b1;
    end
  end

  // Scoreboard: compare state left by the previous edge, then predict the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      served_exp = '0;
    end else begin
      if (mon_en) begin
        check_eq("level", val_t'(level), val_t'(q.size()));
        check_eq("level_max", val_t'(level <= 3'd4), val_t'(1));
        check_eq("served", val_t'(words_served), val_t'(served_exp));
        check_eq("valid", val_t'(rnd_valid), val_t'(q.size() > 0 && !reseed_req));
        if (primed && k >= DISCARD && !rng_reseed && !reseed_req)
          check_eq("enable_run", val_t'(rng_enable),
                   val_t'(q.size() < DEPTH || (q.size() > 0 && rnd_ready)));
      end
      if (reseed_req) begin
        q.delete();
      end else begin
        if (rnd_valid && rnd_ready) begin
          if (q.size() == 0) begin
            check_eq("pop_empty", val_t'(1), val_t'(0));
          end else begin
            check_eq("data", val_t'(rnd_data), val_t'(q.pop_front()));
            served_exp = served_exp + 32'd1;
          end
        end
        if (rng_enable && rng_ready && primed && k >= DISCARD && !rng_reseed)
          q.push_back(word_of(gen, k));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reseed_req = 1'b0; seed_in = '0; rng_ready = 1'b0; rnd_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seed_a[i*32 +: 32] = $urandom;
      seed_b[i*32 +: 32] = $urandom;
    end
    seed_a[399:384] = 16'hBEEF;
    seed_b[399:384] = 16'h1234;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    repeat (10) tick();
    @(negedge clk);
    check_eq("idle_enable", val_t'(rng_enable), val_t'(0));
    check_eq("idle_reseed", val_t'(rng_reseed), val_t'(0));
    check_eq("idle_valid", val_t'(rnd_valid), val_t'(0));
    check_eq("idle_busy", val_t'(busy), val_t'(1));
    check_eq("idle_seed", val_t'(rng_seed), val_t'(0));
    check_eq("idle_data", val_t'(rnd_data), val_t'(0));

    // Reseed and fill
    tick();
    seed_in = seed_a; reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0; seed_in = seed_b;
    @(negedge clk);
    check_eq("rs_reseed", val_t'(rng_reseed), val_t'(1));
    check_eq("rs_enable", val_t'(rng_enable), val_t'(1));
    check_eq("rs_seed", val_t'(rng_seed), val_t'(seed_a));
    tick();
    @(negedge clk);
    check_eq("wait_reseed", val_t'(rng_reseed), val_t'(0));
    check_eq("wait_enable", val_t'(rng_enable), val_t'(1));
    check_eq("wait_seed", val_t'(rng_seed), val_t'(seed_a));
    check_eq("wait_busy", val_t'(busy), val_t'(1));
    repeat (3) tick();
    rng_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level == 3'd4) break;
    end
    check_eq("fill_level", val_t'(level), val_t'(4));
    check_eq("full_enable", val_t'(rng_enable), val_t'(0));
    check_eq("full_busy", val_t'(busy), val_t'(0));
    check_eq("first_word", val_t'(rnd_data), val_t'(word_of(32'd1, 32'd2)));
    repeat (3) tick();
    @(negedge clk);
    check_eq("pause_enable", val_t'(rng_enable), val_t'(0));
    check_eq("pause_data", val_t'(rnd_data), val_t'(word_of(32'd1, 32'd2)));

    // Drain from full with continuous ready
    tick();
    rnd_ready = 1'b1;
    repeat (12) begin
      tick();
      @(negedge clk);
      check_eq("drain_level", val_t'(level), val_t'(4));
    end

    // Backpressure on both sides
    for (int i = 0; i < 40; i++) begin
      tick();
      rnd_ready = (i % 4 == 0 || i % 4 == 2);
      rng_ready = (i % 4 == 1 || i % 4 == 2);
    end

    // Drain to empty, then load exactly three words
    tick();
    rng_ready = 1'b0; rnd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (level == 3'd0) break;
    end
    check_eq("empty_level", val_t'(level), val_t'(0));
    tick();
    rnd_ready = 1'b0; rng_ready = 1'b1;
    repeat (3) tick();
    rng_ready = 1'b0;
    @(negedge clk);
    check_eq("three_level", val_t'(level), val_t'(3));

    // Mid-run reseed with a simultaneous handshake attempt
    tick();
    reseed_req = 1'b1; rnd_ready = 1'b1; seed_in = seed_b;
    @(negedge clk);
    check_eq("mid_valid", val_t'(rnd_valid), val_t'(0));
    tick();
    reseed_req = 1'b0;
    @(negedge clk);
    check_eq("mid_level", val_t'(level), val_t'(0));
    check_eq("mid_reseed", val_t'(rng_reseed), val_t'(1));
    check_eq("mid_seed", val_t'(rng_seed), val_t'(seed_b));
    repeat (4) tick();
    rng_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rnd_valid) break;
    end
    check_eq("mid_first_valid", val_t'(rnd_valid), val_t'(1));
    check_eq("mid_first_word", val_t'(rnd_data), val_t'(word_of(32'd2, 32'd2)));
    repeat (5) tick();

    // Reset while waiting for the RNG
    rnd_ready = 1'b0; rng_ready = 1'b0; reseed_req = 1'b1; seed_in = seed_a;
    tick();
    reseed_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", val_t'(busy), val_t'(1));
    check_eq("rst_enable", val_t'(rng_enable), val_t'(0));
    check_eq("rst_seed", val_t'(rng_seed), val_t'(0));
    tick();
    rng_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check_eq("post_rst_enable", val_t'(rng_enable), val_t'(0));
    check_eq("post_rst_busy", val_t'(busy), val_t'(1));
    check_eq("post_rst_valid", val_t'(rnd_valid), val_t'(0));

    // Recovery after a fresh reseed
    tick();
    reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rnd_valid) break;
    end
    check_eq("rec_valid", val_t'(rnd_valid), val_t'(1));
    check_eq("rec_word", val_t'(rnd_data), val_t'(word_of(32'd4, 32'd2)));
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rng_mask_buffer.md
Name: rng_mask_buffer

Overview:
- Consumer-side front end for the Trivium64-based RNG wrapper; the team's "reader" of the random stream.
- Sequences reseeding of the RNG (drives its enable/reseed/seed, observes its ready flag) and buffers full-width random words in a small FIFO.
- Hands the words to masking gadgets of the cipher datapath through a valid/ready handshake.
- Guarantees no word is delivered twice and no stale word survives a reseed.

Parameters:
- INSTANCES, 5, number of Trivium64 instances in the attached RNG.
- WIDTH, INSTANCES*64, random word width in bits.
- SEED_W, INSTANCES*80, seed width in bits.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- DISCARD, 2, words dropped after each reseed before buffering starts; 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_in  in  SEED_W  seed value, sampled when a reseed starts.
- reseed_req  in  1  one-cycle request to (re)seed the RNG.
- rng_enable  out  1  to RNG enable.
- rng_reseed  out  1  to RNG reseed.
- rng_seed  out  SEED_W  to RNG seed; registered copy of seed_in.
- rng_ready  in  1  from RNG isReady.
- rng_random  in  WIDTH  from RNG random.
- rnd_valid  out  1  head word available to consumer.
- rnd_ready  in  1  consumer accepts head word.
- rnd_data  out  WIDTH  FIFO head word.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  high in any state other than RUN.
- words_served  out  32  count of completed consumer transfers; wraps modulo 2^32.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; FIFO pointers, level, discard counter and words_served all 0; rng_seed=0. All outputs read 0 except busy=1. Reset overrides every other input, including mid-reseed and mid-transfer.
- FSM states: IDLE, RESEED, WAIT_RDY, DROP, RUN.
- IDLE:
  - rng_enable=0, rnd_valid=0.
  - reseed_req -> RESEED.
- RESEED (exactly 1 cycle):
  - rng_reseed=1, rng_enable=1, rng_seed already holding the seed_in captured on the edge that entered RESEED.
  - FIFO flushed (pointers and level to 0) on the edge entering RESEED.
  - Discard counter loaded with DISCARD.
  - Next state: WAIT_RDY.
- WAIT_RDY:
  - rng_enable=1, rng_reseed=0.
  - Stays until rng_ready=1, then -> DROP if DISCARD>0, else -> RUN.
- DROP:
  - rng_enable=1.
  - Each cycle with rng_ready=1 decrements the discard counter; the word is not stored.
  - Counter reaching 0 -> RUN.
- RUN:
  - rng_enable = (level < DEPTH) OR (rnd_valid AND rnd_ready).
  - A word is captured into the FIFO tail on any edge where rng_enable=1 and rng_ready=1; write latency is 1 cycle.
  - rnd_valid = (level > 0). rnd_data is the head word, combinational from FIFO storage; it is stable while rnd_valid=1 and rnd_ready=0.
  - A transfer occurs on an edge where rnd_valid=1 and rnd_ready=1: head pointer advances and words_served increments.
  - Simultaneous push and pop: level unchanged, both pointers advance; this is legal at level=DEPTH.
  - Full (level=DEPTH) with no pop: rng_enable=0, and the RNG is paused, not dropped.
  - Empty: rnd_valid=0; rnd_ready is ignored.
  - rng_ready falling in RUN: no capture, state unchanged.
- reseed_req in any non-IDLE state (including RESEED, WAIT_RDY and DROP) restarts at RESEED on the next edge, with a new seed capture and flush. Any handshake in that same cycle is ignored: rnd_valid is forced 0 during that cycle and words_served does not increment.
- level always equals writes minus reads since the last flush. Pointers wrap modulo DEPTH.
- busy = (state != RUN).

Test Plan:
- Reset then idle: hold rst 3 cycles, then 10 cycles idle -> rng_enable=0, rng_reseed=0, rnd_valid=0, level=0, busy=1, words_served=0.
- Reseed and fill (DEPTH=4, DISCARD=2, RNG model returning incrementing words W0,W1,... with rng_ready asserted 5 cycles after reseed, rnd_ready=0):
  - rng_reseed high exactly 1 cycle; rng_seed equals seed_in.
  - W0 and W1 are dropped; W2..W5 are buffered.
  - level=4, then rng_enable=0.
- Drain: from full, rnd_ready=1 continuously -> rnd_data sequence W2,W3,W4,W5,W6,... with no gaps; level stays 4; words_served increments every cycle.
- Backpressure: rnd_ready toggles 1010 while rng_ready toggles 0110 -> every word delivered exactly once and in order; level never exceeds 4 or goes below 0.
- Mid-run reseed: at level=3 assert reseed_req together with rnd_ready=1 -> no transfer that cycle; level=0 next cycle; first delivered word after the new ready is the third word the RNG produces post-reseed.
- Reset mid-WAIT_RDY: assert rst while waiting on rng_ready -> IDLE next cycle; rng_enable=0; rng_seed=0; a later rng_ready pulse has no effect until reseed_req.
